dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the core MEM stage, port 1 is the debug/DMA loader.
- Arbitrates per cycle, drives the memory command/address/data bus, and checks alignment.
- Registers load data one cycle after the grant, with byte/half lane extraction and sign/zero extension.
- Sits between the MEM stage / loader and data_mem. It is the only driver of the memory command bus.

---
 rtl/dmem_pkg.sv | 68 ++++++
 rtl/dmem_load_align.sv | 40 ++++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : memory command codes, arbiter state type, command classifiers
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [3:0] c_MEM_NONE = 4'd0;
  localparam logic [3:0] c_MEM_LB   = 4'd1;
  localparam logic [3:0] c_MEM_LH   = 4'd2;
  localparam logic [3:0] c_MEM_LW   = 4'd3;
  localparam logic [3:0] c_MEM_LBU  = 4'd4;
  localparam logic [3:0] c_MEM_LHU  = 4'd5;
  localparam logic [3:0] c_MEM_SB   = 4'd6;
  localparam logic [3:0] c_MEM_SH   = 4'd7;
  localparam logic [3:0] c_MEM_SW   = 4'd8;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  function automatic logic is_load(input logic [3:0] cmd);
    return (cmd == c_MEM_LB) || (cmd == c_MEM_LH) || (cmd == c_MEM_LW) ||
           (cmd == c_MEM_LBU) || (cmd == c_MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] cmd);
    return (cmd == c_MEM_SB) || (cmd == c_MEM_SH) || (cmd == c_MEM_SW);
  endfunction

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return is_load(cmd) || is_store(cmd);
  endfunction

  function automatic acc_size_t access_size(input logic [3:0] cmd);
    acc_size_t sz;
    sz = SZ_BYTE;
    if ((cmd == c_MEM_LH) || (cmd == c_MEM_LHU) || (cmd == c_MEM_SH)) sz = SZ_HALF;
    if ((cmd == c_MEM_LW) || (cmd == c_MEM_SW)) sz = SZ_WORD;
    return sz;
  endfunction

  function automatic logic is_signed(input logic [3:0] cmd);
    return (cmd == c_MEM_LB) || (cmd == c_MEM_LH);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] cmd, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (is_valid_cmd(cmd)) begin
      case (access_size(cmd))
        SZ_HALF: mis = addr_lo[0];
        SZ_WORD: mis = |addr_lo;
        default: mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// dmem_load_align : byte/half lane select and sign/zero extension of a load
// Revision : 1.0
// ============================================================================
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [3:0]  i_cmd,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    w_sext = is_signed(i_cmd);
    o_data = '0;
    // Non-load commands (stores, NONE) yield zero so the caller can register it blindly
    if (is_load(i_cmd)) begin
      case (access_size(i_cmd))
        SZ_BYTE: o_data = {{24{w_sext & w_byte[7]}}, w_byte};
        SZ_HALF: o_data = {{16{w_sext & w_half[15]}}, w_half};
        default: o_data = i_word;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : two-port arbiter (core / loader) in front of single-port dmem
// Revision : 1.0
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [3:0]  p0_cmd,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_din,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [3:0]  p1_cmd,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_din,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [3:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam int c_WAIT_W  = (MAX_WAIT < 3) ? 2 : $clog2(MAX_WAIT + 1);
  localparam int c_BURST_W = (BURST_MAX < 2) ? 2 : $clog2(BURST_MAX + 1);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_MAX  = c_WAIT_W'(MAX_WAIT);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_TWO  = c_WAIT_W'(2);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(BURST_MAX);
  localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);

  arb_state_t           r_state, w_state_nxt;
  logic [c_WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
  logic [c_BURST_W-1:0] r_burst_cnt, w_burst_nxt;
  logic                 r_rr_last, w_rr_nxt;

  logic        w_v0, w_v1, w_p1_pri, w_gnt0, w_gnt1, w_mis;
  logic [3:0]  w_cmd;
  logic [31:0] w_addr, w_din, w_ld_data, w_rsp_data;

  logic        r_p0_rvalid, r_p0_err, r_p1_rvalid, r_p1_err;
  logic [31:0] r_p0_rdata, r_p1_rdata;

  assign w_v0 = p0_req & is_valid_cmd(p0_cmd);
  assign w_v1 = p1_req & is_valid_cmd(p1_cmd);
  // Loader wins a contended cycle when starved, or when the core won last and loader has waited twice
  assign w_p1_pri = (r_wait_cnt == c_WAIT_MAX) || (!r_rr_last && (r_wait_cnt >= c_WAIT_TWO));

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_rr_nxt    = r_rr_last;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      ARB: begin
        if (w_v0 && w_v1) begin
          w_gnt1 = w_p1_pri;
          w_gnt0 = !w_p1_pri;
        end else begin
          w_gnt0 = w_v0;
          w_gnt1 = w_v1;
        end
        if (w_gnt0 || w_gnt1) w_rr_nxt = w_gnt1;
        if (w_gnt1 && p1_lock) begin
          w_state_nxt = BURST;
          w_burst_nxt = c_BURST_ONE;
        end
      end
      BURST: begin
        w_gnt1 = w_v1 && (r_burst_cnt != c_BURST_MAX);
        if (w_gnt1) w_burst_nxt = r_burst_cnt + c_BURST_ONE;
        if (!p1_lock || !p1_req || (r_burst_cnt == c_BURST_MAX)) begin
          w_state_nxt = ARB;
          w_rr_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    w_wait_nxt = r_wait_cnt;
    if (w_gnt1)                                    w_wait_nxt = '0;
    else if (p1_req && (r_wait_cnt != c_WAIT_MAX)) w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
  end

  always_comb begin
    w_cmd  = c_MEM_NONE;
    w_addr = '0;
    w_din  = '0;
    if (w_gnt0) begin
      w_cmd  = p0_cmd;
      w_addr = p0_addr;
      w_din  = p0_din;
    end else if (w_gnt1) begin
      w_cmd  = p1_cmd;
      w_addr = p1_addr;
      w_din  = p1_din;
    end
  end

  assign w_mis      = is_misaligned(w_cmd, w_addr[1:0]);
  assign mem_cmd    = w_mis ? c_MEM_NONE : w_cmd;
  assign mem_addr   = w_addr;
  assign mem_din    = w_din;
  assign w_rsp_data = w_mis ? 32'd0 : w_ld_data;

  dmem_load_align u_load_align (
    .i_word    (mem_dout),
    .i_addr_lo (w_addr[1:0]),
    .i_cmd     (w_cmd),
    .o_data    (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_rr_last   <= 1'b1;
      r_p0_rvalid <= 1'b0;
      r_p0_err    <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rvalid <= 1'b0;
      r_p1_err    <= 1'b0;
      r_p1_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rr_last   <= w_rr_nxt;
      r_p0_rvalid <= w_gnt0;
      r_p0_err    <= w_gnt0 & w_mis;
      r_p0_rdata  <= w_gnt0 ? w_rsp_data : 32'd0;
      r_p1_rvalid <= w_gnt1;
      r_p1_err    <= w_gnt1 & w_mis;
      r_p1_rdata  <= w_gnt1 ? w_rsp_data : 32'd0;
    end
  end

  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;
  assign p0_rvalid = r_p0_rvalid;
  assign p0_err    = r_p0_err;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rvalid = r_p1_rvalid;
  assign p1_err    = r_p1_err;
  assign p1_rdata  = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed + random stimulus against a cycle reference model
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_gnt, p0_rvalid, p0_err;
  logic [3:0]  p0_cmd;
  logic [31:0] p0_addr, p0_din, p0_rdata;
  logic        p1_req, p1_lock, p1_gnt, p1_rvalid, p1_err;
  logic [3:0]  p1_cmd;
  logic [31:0] p1_addr, p1_din, p1_rdata;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_addr, mem_din, mem_dout;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory behaviour (environment + reference copy) ----------------
  function automatic logic [31:0] t_merge(input logic [31:0] old, input logic [3:0] c,
                                          input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (c == c_MEM_SW) return d;
    if (c == c_MEM_SB) begin sh = 8 * int'(a % 4);       mask = 32'hFF << sh;   end
    else               begin sh = 16 * int'((a / 2) % 2); mask = 32'hFFFF << sh; end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  bit          mem_copy;

  assign mem_dout = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_copy) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
    end else if (mem_cmd == c_MEM_SB || mem_cmd == c_MEM_SH || mem_cmd == c_MEM_SW) begin
      env_mem[mem_addr[9:2]] <= t_merge(env_mem[mem_addr[9:2]], mem_cmd, mem_addr, mem_din);
    end
  end

  // ---------------- reference model ----------------
  function automatic bit t_load(input logic [3:0] c);
    return c >= 4'd1 && c <= 4'd5;
  endfunction
  function automatic bit t_store(input logic [3:0] c);
    return c >= 4'd6 && c <= 4'd8;
  endfunction
  function automatic bit t_mis(input logic [3:0] c, input logic [31:0] a);
    if (c == c_MEM_LH || c == c_MEM_LHU || c == c_MEM_SH) return (a % 2) != 0;
    if (c == c_MEM_LW || c == c_MEM_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction
  function automatic logic [31:0] t_ext(input logic [31:0] w, input logic [3:0] c,
                                        input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (c)
      c_MEM_LB:  return (b >= 32'd128)   ? b - 32'd256     : b;
      c_MEM_LBU: return b;
      c_MEM_LH:  return (h >= 32'h8000)  ? h - 32'h10000   : h;
      c_MEM_LHU: return h;
      default:   return w;
    endcase
  endfunction

  bit          m_burst, m_rr;
  int          m_wait, m_bcnt;
  bit          e_rv0, e_rv1, e_err0, e_err1;
  logic [31:0] e_rd0, e_rd1;
  bit          g0, g1, o_g0, o_g1;

  task automatic model_reset();
    m_burst = 0; m_rr = 1; m_wait = 0; m_bcnt = 0;
    e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0; e_rd0 = 0; e_rd1 = 0;
    g0 = 0; g1 = 0;
  endtask

  // One clock: entered at posedge+1 with inputs applied, left at next posedge+1
  task automatic tick();
    bit v0, v1, xb, mis;
    logic [3:0]  ec;
    logic [31:0] ea, ed, word;
    @(negedge clk);
    v0 = p0_req && p0_cmd >= 4'd1 && p0_cmd <= 4'd8;
    v1 = p1_req && p1_cmd >= 4'd1 && p1_cmd <= 4'd8;
    g0 = 0; g1 = 0; xb = 0;
    if (!m_burst) begin
      if (v0 && !v1) g0 = 1;
      else if (v1 && !v0) g1 = 1;
      else if (v0 && v1) begin
        if (m_wait == MAX_WAIT || (!m_rr && m_wait >= 2)) g1 = 1; else g0 = 1;
      end
    end else begin
      g1 = v1 && (m_bcnt < BURST_MAX);
      xb = !p1_lock || !p1_req || (m_bcnt == BURST_MAX);
    end
    ec = c_MEM_NONE; ea = 0; ed = 0;
    if (g0)      begin ec = p0_cmd; ea = p0_addr; ed = p0_din; end
    else if (g1) begin ec = p1_cmd; ea = p1_addr; ed = p1_din; end
    mis = t_mis(ec, ea);
    o_g0 = p0_gnt; o_g1 = p1_gnt;
    chk("p0_gnt",    {31'd0, p0_gnt},    {31'd0, g0});
    chk("p1_gnt",    {31'd0, p1_gnt},    {31'd0, g1});
    chk("mem_cmd",   {28'd0, mem_cmd},   {28'd0, (mis ? c_MEM_NONE : ec)});
    chk("mem_addr",  mem_addr,           ea);
    chk("mem_din",   mem_din,            ed);
    chk("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e_rv0});
    chk("p0_err",    {31'd0, p0_err},    {31'd0, e_err0});
    chk("p0_rdata",  p0_rdata,           e_rd0);
    chk("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e_rv1});
    chk("p1_err",    {31'd0, p1_err},    {31'd0, e_err1});
    chk("p1_rdata",  p1_rdata,           e_rd1);
    @(posedge clk);
    word   = ref_mem[ea[9:2]];
    e_rv0  = g0; e_err0 = g0 && mis;
    e_rd0  = (g0 && t_load(ec) && !mis) ? t_ext(word, ec, ea) : 32'd0;
    e_rv1  = g1; e_err1 = g1 && mis;
    e_rd1  = (g1 && t_load(ec) && !mis) ? t_ext(word, ec, ea) : 32'd0;
    if ((g0 || g1) && t_store(ec) && !mis) ref_mem[ea[9:2]] = t_merge(word, ec, ea, ed);
    if (!m_burst) begin
      if (g0 || g1) m_rr = g1;
      if (g1 && p1_lock) begin m_burst = 1; m_bcnt = 1; end
    end else begin
      if (g1) m_bcnt++;
      if (xb) begin m_burst = 0; m_rr = 1; end
    end
    if (g1) m_wait = 0;
    else if (p1_req) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    #1;
  endtask

  task automatic set0(input bit r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    p0_req = r; p0_cmd = c; p0_addr = a; p0_din = d;
  endtask
  task automatic set1(input bit r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                      input bit l);
    p1_req = r; p1_cmd = c; p1_addr = a; p1_din = d; p1_lock = l;
  endtask

  task automatic gen0();
    logic [31:0] a;
    a = $urandom_range(0, 1023);
    if ($urandom % 2 == 0) a[1:0] = 2'b00;
    p0_req  = ($urandom % 4) != 0;
    p0_cmd  = ($urandom % 16 == 0) ? 4'(9 + $urandom % 7) : 4'($urandom_range(1, 8));
    p0_addr = a;
    p0_din  = $urandom;
  endtask
  task automatic gen1();
    logic [31:0] a;
    a = $urandom_range(0, 1023);
    if ($urandom % 2 == 0) a[1:0] = 2'b00;
    p1_req  = ($urandom % 4) != 0;
    p1_cmd  = 4'($urandom_range(1, 8));
    p1_addr = a;
    p1_din  = $urandom;
    p1_lock = ($urandom % 3) == 0;
  endtask

  int gseq [0:63];

  initial begin
    int k, n, f, run, j, lat;
    logic [31:0] d;
    rst = 1'b1;
    set0(0, c_MEM_NONE, 0, 0);
    set1(0, c_MEM_NONE, 0, 0, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8] = 32'h12345678;
    mem_copy = 1;
    model_reset();
    repeat (2) @(posedge clk);
    mem_copy = 0;
    #1;
    chk("rst_mem_cmd", {28'd0, mem_cmd}, {28'd0, c_MEM_NONE});
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    tick();

    // Port 0 alone: store then loads with lane extraction
    set0(1, c_MEM_SW, 32'h10, 32'hDEADBEEF); tick();
    set0(1, c_MEM_LW, 32'h10, 32'h0); tick();
    chk("lw_0x10", p0_rdata, 32'hDEADBEEF);
    set0(1, c_MEM_LB, 32'h13, 32'h0); tick();
    chk("lb_0x13", p0_rdata, 32'hFFFFFFDE);
    set0(1, c_MEM_LBU, 32'h13, 32'h0); tick();
    chk("lbu_0x13", p0_rdata, 32'h000000DE);

    // Misaligned half store: granted, no write, error response
    set0(1, c_MEM_SH, 32'h21, 32'hAAAA5555); #1;
    chk("mis_mem_cmd", {28'd0, mem_cmd}, {28'd0, c_MEM_NONE});
    chk("mis_gnt", {31'd0, p0_gnt}, 32'd1);
    tick();
    chk("mis_err", {31'd0, p0_err}, 32'd1);
    chk("mis_rvalid", {31'd0, p0_rvalid}, 32'd1);
    set0(1, c_MEM_LW, 32'h20, 32'h0); tick();
    chk("mis_unchanged", p0_rdata, 32'h12345678);

    // Starvation: both held high
    set0(1, c_MEM_LW, 32'h0, 0);
    set1(1, c_MEM_LW, 32'h4, 0, 0);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      gseq[i] = o_g1 ? 1 : (o_g0 ? 0 : 2);
      if (g1 && lat < 0) lat = i + 1;
    end
    chk("starve_lat", {31'd0, (lat >= 1 && lat <= MAX_WAIT + 1)}, 32'd1);
    if (lat >= 1) chk("starve_then_p0", gseq[lat], 32'd0);

    // Locked burst of 10 stores with core contending
    set0(0, c_MEM_NONE, 0, 0); set1(0, c_MEM_NONE, 0, 0, 0); tick();
    for (int i = 0; i < 64; i++) gseq[i] = 3;
    set0(1, c_MEM_LW, 32'h0, 0);
    set1(1, c_MEM_SW, 32'h40, $urandom, 1);
    k = 0; n = 0;
    for (int i = 0; i < 40 && k < 10; i++) begin
      tick();
      gseq[n] = o_g1 ? 1 : (o_g0 ? 0 : 2);
      n++;
      if (g1) begin
        k++;
        if (k < 10) begin p1_addr = 32'h40 + 32'(4 * k); p1_din = $urandom; end
        else begin p1_req = 0; p1_lock = 0; end
      end
    end
    chk("burst_done", k, 10);
    f = 0;
    while (f < n && gseq[f] != 1) f++;
    run = 0; j = f;
    while (j < n && gseq[j] == 1) begin run++; j++; end
    chk("burst_run", run, BURST_MAX);
    while (j < n && gseq[j] == 2) j++;
    chk("burst_then_p0", gseq[j], 0);
    j++;
    while (j < n && gseq[j] == 2) j++;
    chk("burst_p1_resume", gseq[j], 1);

    // Reset during the third beat of a burst
    set0(0, c_MEM_NONE, 0, 0); set1(0, c_MEM_NONE, 0, 0, 0); tick();
    set1(1, c_MEM_SW, 32'h80, $urandom, 1); tick();
    set0(1, c_MEM_LW, 32'h0, 0); p1_addr = 32'h84; tick();
    p1_addr = 32'h88;
    #2 rst = 1'b1;
    #1;
    chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_mem_cmd2", {28'd0, mem_cmd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_p1_rvalid2", {31'd0, p1_rvalid}, 32'd0);
    model_reset();
    set0(0, c_MEM_NONE, 0, 0); set1(0, c_MEM_NONE, 0, 0, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    set0(1, c_MEM_LW, 32'h0, 0);
    set1(1, c_MEM_LW, 32'h4, 0, 0);
    tick();
    chk("rst_then_p0", {31'd0, o_g0}, 32'd1);

    // Back-to-back alternating core store / loader load
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        d = $urandom;
        set0(1, c_MEM_SW, 32'h100 + 32'(4 * i), d);
        set1(0, c_MEM_NONE, 0, 0, 0);
      end else begin
        set0(0, c_MEM_NONE, 0, 0);
        set1(1, c_MEM_LW, 32'h100 + 32'(4 * (i - 1)), 0, 0);
      end
      tick();
      chk("b2b_rv0", {31'd0, p0_rvalid}, {31'd0, (i % 2 == 0)});
      chk("b2b_rv1", {31'd0, p1_rvalid}, {31'd0, (i % 2 == 1)});
      if (i % 2 == 1) chk("b2b_rdata", p1_rdata, d);
    end

    // Random traffic
    gen0(); gen1();
    for (int i = 0; i < 600; i++) begin
      tick();
      if (g0 || !p0_req || p0_cmd > 4'd8) gen0();
      if (g1 || !p1_req) gen1();
      else if ($urandom % 8 == 0) p1_lock = ~p1_lock;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
